cam_capture_rgb332: RTL and testbench

- Camera capture stage that sits directly upstream of the dual-port frame buffer's write port.
- Samples the OV7670 parallel bus (RGB565, two bytes per pixel, QQVGA 160x120).
- Packs each pixel to RGB332 and issues one write per pixel (address, data, strobe) into the frame buffer.
- Locks to VSYNC, so only whole frames are written; reports frame completion and overflow.

---
 rtl/cam_capture_rgb332_pkg.sv | 25 ++
 rtl/cam_capture_rgb332_if.sv | 31 +++
 rtl/cam_capture_rgb332_byte_pack.sv | 72 +++++++
 rtl/cam_capture_rgb332.sv | 132 +++++++++++++
 tb/tb_cam_capture_rgb332.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/cam_capture_rgb332_pkg.sv
// ---------------------------------------------------------------------------
// cam_capture_rgb332_pkg
// Shared camera definitions: capture FSM state encoding, QQVGA geometry and
// the RGB565 -> RGB332 packing used by the capture path, the VGA readout
// path and software-side models.
// ---------------------------------------------------------------------------
package cam_capture_rgb332_pkg;

    // QQVGA geometry
    localparam int H_PIX = 160;
    localparam int V_PIX = 120;
    localparam int NPIX  = H_PIX * V_PIX;

    // Capture FSM state encoding (kept as plain constants for legacy users)
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_VBLANK  = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    // Keep the top three bits of R and G and the top two bits of B.
    function automatic logic [7:0] rgb565_to_rgb332(input logic [15:0] px);
        return {px[15:13], px[10:8], px[4:3]};
    endfunction

endpackage

// File: rtl/cam_capture_rgb332_if.sv
// ---------------------------------------------------------------------------
// cam_capture_rgb332_if
// Bundles the camera parallel bus (in), the capture enable and the
// frame-buffer write port plus status (out) of the capture stage.
//   master : drives cam_en/vsync/href/px_data, observes the write port
//   slave  : the capture stage itself
// ---------------------------------------------------------------------------
interface cam_capture_rgb332_if #(
    parameter int AW = 15,
    parameter int DW = 8
);
    logic          cam_en;
    logic          vsync;
    logic          href;
    logic [7:0]    px_data;
    logic [AW-1:0] mem_px_addr;
    logic [DW-1:0] mem_px_data;
    logic          px_wr;
    logic          frame_done;
    logic          overflow;

    modport master (
        output cam_en, vsync, href, px_data,
        input  mem_px_addr, mem_px_data, px_wr, frame_done, overflow
    );

    modport slave (
        input  cam_en, vsync, href, px_data,
        output mem_px_addr, mem_px_data, px_wr, frame_done, overflow
    );
endinterface

// File: rtl/cam_capture_rgb332_byte_pack.sv
// ---------------------------------------------------------------------------
// cam_byte_pack
// Assembles RGB565 byte pairs into RGB332 pixels and issues the write strobe.
//   pclk, rst  : clock, async active-high reset
//   capture_en : FSM is in CAPTURE
//   wr_allow   : frame buffer still has room for another pixel
//   href_q     : registered HREF
//   byte_q     : registered camera byte
//   px_wr      : one-cycle write strobe (registered)
//   px_data    : packed RGB332 pixel, held between writes (registered)
//   drop       : one-cycle pulse for a pixel completed with no room left
// ---------------------------------------------------------------------------
module cam_byte_pack
    import cam_capture_rgb332_pkg::*;
(
    input  logic       pclk,
    input  logic       rst,
    input  logic       capture_en,
    input  logic       wr_allow,
    input  logic       href_q,
    input  logic [7:0] byte_q,
    output logic       px_wr,
    output logic [7:0] px_data,
    output logic       drop
);

    logic       phase_r;
    logic [7:0] hi_r;
    logic       px_wr_r;
    logic [7:0] px_data_r;
    logic       drop_r;
    logic       pix_done_s;

    // A pixel completes on the second valid byte of a pair.
    always_comb begin
        pix_done_s = capture_en && href_q && phase_r;
    end

    // Byte-phase flag, hi-byte latch and registered write/drop generation.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            phase_r   <= 1'b0;
            hi_r      <= 8'h00;
            px_wr_r   <= 1'b0;
            px_data_r <= 8'h00;
            drop_r    <= 1'b0;
        end else begin
            px_wr_r <= 1'b0;
            drop_r  <= 1'b0;
            // Leaving a line (or capture) discards any dangling odd byte.
            if (!capture_en || !href_q) begin
                phase_r <= 1'b0;
            end else begin
                phase_r <= ~phase_r;
                if (!phase_r) begin
                    hi_r <= byte_q;
                end
            end
            if (pix_done_s && wr_allow) begin
                px_wr_r   <= 1'b1;
                px_data_r <= rgb565_to_rgb332({hi_r, byte_q});
            end else if (pix_done_s) begin
                drop_r <= 1'b1;
            end
        end
    end

    assign px_wr   = px_wr_r;
    assign px_data = px_data_r;
    assign drop    = drop_r;

endmodule

// File: rtl/cam_capture_rgb332.sv
// ---------------------------------------------------------------------------
// cam_capture_rgb332
// OV7670 RGB565 capture into an RGB332 frame buffer, locked to VSYNC so only
// whole frames are written.
//   pclk : camera pixel clock, all logic on the rising edge
//   rst  : asynchronous active-high reset
//   bus  : cam_capture_rgb332_if.slave
//          in : cam_en, vsync, href, px_data
//          out: mem_px_addr, mem_px_data, px_wr, frame_done, overflow
// ---------------------------------------------------------------------------
module cam_capture_rgb332 #(
    parameter int AW    = 15,
    parameter int DW    = 8,
    parameter int H_PIX = cam_capture_rgb332_pkg::H_PIX,
    parameter int V_PIX = cam_capture_rgb332_pkg::V_PIX
) (
    input  logic                 pclk,
    input  logic                 rst,
    cam_capture_rgb332_if.slave  bus
);
    import cam_capture_rgb332_pkg::*;

    localparam logic [AW-1:0] LAST_ADDR = AW'(H_PIX * V_PIX - 1);

    logic          vsync_r;
    logic          href_r;
    logic [7:0]    data_r;
    logic [1:0]    state_r;
    logic [1:0]    state_nx_s;
    logic [AW-1:0] addr_r;
    logic          full_r;
    logic          frame_done_r;
    logic          overflow_r;
    logic          start_s;
    logic          px_wr_s;
    logic          drop_s;
    logic [7:0]    px_data_s;

    // Single input register stage; the camera bus shares pclk.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            vsync_r <= 1'b0;
            href_r  <= 1'b0;
            data_r  <= 8'h00;
        end else begin
            vsync_r <= bus.vsync;
            href_r  <= bus.href;
            data_r  <= bus.px_data;
        end
    end

    // Next-state logic; capture only starts on a vsync high->low edge seen in VBLANK.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.cam_en && vsync_r) state_nx_s = ST_VBLANK;
                else                       state_nx_s = ST_IDLE;
            end
            ST_VBLANK: begin
                if (!vsync_r) state_nx_s = ST_CAPTURE;
                else          state_nx_s = ST_VBLANK;
            end
            ST_CAPTURE: begin
                if (vsync_r) state_nx_s = ST_DONE;
                else         state_nx_s = ST_CAPTURE;
            end
            ST_DONE: begin
                if (bus.cam_en) state_nx_s = ST_VBLANK;
                else            state_nx_s = ST_IDLE;
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Frame start strobe: the VBLANK -> CAPTURE transition.
    always_comb begin
        start_s = (state_r == ST_VBLANK) && !vsync_r;
    end

    // State register and the registered end-of-frame pulse (coincides with DONE).
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            frame_done_r <= (state_r == ST_CAPTURE) && vsync_r;
        end
    end

    // Address counter saturates at the last pixel; full_r marks that it was written.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            addr_r     <= {AW{1'b0}};
            full_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else if (start_s) begin
            addr_r     <= {AW{1'b0}};
            full_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            if (px_wr_s) begin
                if (addr_r == LAST_ADDR) full_r <= 1'b1;
                else                     addr_r <= addr_r + {{(AW-1){1'b0}}, 1'b1};
            end else begin
                full_r <= full_r;
            end
            if (drop_s) overflow_r <= 1'b1;
            else        overflow_r <= overflow_r;
        end
    end

    cam_byte_pack u_pack (
        .pclk       (pclk),
        .rst        (rst),
        .capture_en (state_r == ST_CAPTURE),
        .wr_allow   (!full_r),
        .href_q     (href_r),
        .byte_q     (data_r),
        .px_wr      (px_wr_s),
        .px_data    (px_data_s),
        .drop       (drop_s)
    );

    assign bus.mem_px_addr = addr_r;
    assign bus.mem_px_data = DW'(px_data_s);
    assign bus.px_wr       = px_wr_s;
    assign bus.frame_done  = frame_done_r;
    assign bus.overflow    = overflow_r;

endmodule

// File: tb/tb_cam_capture_rgb332.sv
// ---------------------------------------------------------------------------
// tb_cam_capture_rgb332
// Randomised camera frames driven into cam_capture_rgb332; every frame-buffer
// write is recorded and compared with a reference model that counts pixel
// pairs per line and converts RGB565 to RGB332 arithmetically.
// ---------------------------------------------------------------------------
module tb_cam_capture_rgb332;

    localparam int NPIX = 19200;

    typedef struct packed {
        logic [14:0] a;
        logic [7:0]  d;
    } wr_t;

    logic pclk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   done_cnt = 0;
    bit   ovf_exp = 1'b0;
    wr_t  obs_q[$];
    wr_t  exp_q[$];

    always #5 pclk = ~pclk;

    cam_capture_rgb332_if #(.AW(15), .DW(8)) bus ();

    cam_capture_rgb332 #(.AW(15), .DW(8), .H_PIX(160), .V_PIX(120)) dut (
        .pclk (pclk),
        .rst  (rst),
        .bus  (bus)
    );

    // Record every write and count end-of-frame pulses.
    always @(negedge pclk) begin
        if (bus.px_wr === 1'b1) obs_q.push_back({bus.mem_px_addr, bus.mem_px_data});
        if (bus.frame_done === 1'b1) done_cnt++;
    end

    function automatic logic [7:0] to332(input int pix);
        int r, g, b;
        r = pix / 2048;
        g = (pix / 32) % 64;
        b = pix % 32;
        return 8'((r / 4) * 32 + (g / 8) * 4 + b / 8);
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge pclk);
    endtask

    // One frame: vsync blanking, lines of the given byte counts, vsync again.
    task automatic send_frame(input int lens[$], input bit pattern, input int drop_line, input bit cap);
        int pix;
        int n;
        n = 0;
        pix = 0;
        bus.vsync = 1'b1; bus.href = 1'b0; idle(4);
        bus.vsync = 1'b0; idle(4);
        exp_q.delete();
        if (cap) ovf_exp = 1'b0;
        foreach (lens[l]) begin
            if (l == drop_line) bus.cam_en = 1'b0;
            for (int b = 0; b < lens[l]; b++) begin
                if (b % 2 == 0) begin
                    if (pattern) pix = (n % 2 == 0) ? 32'hF800 : 32'h001F;
                    else         pix = int'($urandom_range(0, 65535));
                    bus.px_data = 8'(pix / 256);
                end else begin
                    bus.px_data = 8'(pix % 256);
                    if (cap) begin
                        if (n < NPIX) exp_q.push_back({15'(n), to332(pix)});
                        else          ovf_exp = 1'b1;
                    end
                    n++;
                end
                bus.href = 1'b1;
                @(negedge pclk);
            end
            bus.href = 1'b0;
            bus.px_data = 8'($urandom);
            idle(int'($urandom_range(2, 5)));
        end
        bus.vsync = 1'b1;
        idle(6);
    endtask

    task automatic test_reset();
        int s;
        rst = 1'b1; bus.cam_en = 1'b1; bus.vsync = 1'b0; bus.href = 1'b0; bus.px_data = 8'h00;
        repeat (3) begin @(negedge pclk); bus.href = ~bus.href; end
        n_cmp++;
        if ({bus.px_wr, bus.frame_done, bus.overflow} !== 3'b000) begin
            n_bad++; $display("FAIL reset_flags: got %b expected 000", {bus.px_wr, bus.frame_done, bus.overflow});
        end
        n_cmp++;
        if ({bus.mem_px_addr, bus.mem_px_data} !== 23'h0) begin
            n_bad++; $display("FAIL reset_addr_data: got %h/%h expected 0/0", bus.mem_px_addr, bus.mem_px_data);
        end
        rst = 1'b0;
        s = obs_q.size();
        repeat (40) begin bus.href = ~bus.href; bus.px_data = 8'($urandom); @(negedge pclk); end
        n_cmp++;
        if (obs_q.size() - s !== 0) begin
            n_bad++; $display("FAIL reset_no_sync_writes: got %0d expected 0", obs_q.size() - s);
        end
        // Start a frame, write a few pixels, then reset in the middle of it.
        bus.href = 1'b0; bus.vsync = 1'b1; idle(4); bus.vsync = 1'b0; idle(4);
        repeat (8) begin bus.href = 1'b1; bus.px_data = 8'($urandom); @(negedge pclk); end
        bus.href = 1'b0; idle(3);
        n_cmp++;
        if (obs_q.size() - s !== 4) begin
            n_bad++; $display("FAIL pre_reset_writes: got %0d expected 4", obs_q.size() - s);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.px_wr, bus.mem_px_addr, bus.mem_px_data} !== 24'h0) begin
            n_bad++; $display("FAIL async_reset: got wr=%b addr=%0d data=%h expected 0", bus.px_wr, bus.mem_px_addr, bus.mem_px_data);
        end
        repeat (3) begin @(negedge pclk); bus.href = ~bus.href; end
        rst = 1'b0;
        s = obs_q.size();
        repeat (40) begin bus.href = ~bus.href; bus.px_data = 8'($urandom); @(negedge pclk); end
        bus.href = 1'b0; idle(3);
        n_cmp++;
        if (obs_q.size() - s !== 0) begin
            n_bad++; $display("FAIL reset_midframe_writes: got %0d expected 0", obs_q.size() - s);
        end
    endtask

    task automatic test_single_pixel();
        int s, d0;
        s = obs_q.size(); d0 = done_cnt;
        bus.vsync = 1'b1; idle(4); bus.vsync = 1'b0; idle(4);
        bus.href = 1'b1; bus.px_data = 8'h07; @(negedge pclk);
        bus.px_data = 8'hE0; @(negedge pclk);
        bus.href = 1'b0;
        n_cmp++;
        if (bus.px_wr !== 1'b0) begin
            n_bad++; $display("FAIL single_early_wr: got %b expected 0", bus.px_wr);
        end
        @(negedge pclk);
        n_cmp++;
        if ({bus.px_wr, bus.mem_px_addr, bus.mem_px_data} !== {1'b1, 15'd0, 8'h1C}) begin
            n_bad++; $display("FAIL single_write: got wr=%b addr=%0d data=%h expected 1/0/1c", bus.px_wr, bus.mem_px_addr, bus.mem_px_data);
        end
        idle(3); bus.vsync = 1'b1; idle(6);
        n_cmp++;
        if (done_cnt - d0 !== 1 || obs_q.size() - s !== 1 || bus.overflow !== 1'b0) begin
            n_bad++; $display("FAIL single_frame: got done=%0d writes=%0d ovf=%b expected 1/1/0", done_cnt - d0, obs_q.size() - s, bus.overflow);
        end
    endtask

    // Runs a frame and checks the write stream, done count and overflow.
    task automatic run_and_check(input string name, input int lens[$], input bit pattern, input int drop_line, input bit cap);
        int s, d0, bad;
        s = obs_q.size(); d0 = done_cnt; bad = -1;
        send_frame(lens, pattern, drop_line, cap);
        n_cmp++;
        if (obs_q.size() - s !== exp_q.size()) begin
            n_bad++; $display("FAIL %s writes: got %0d expected %0d", name, obs_q.size() - s, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && bad < 0; i++)
            if (s + i >= obs_q.size() || obs_q[s + i] !== exp_q[i]) bad = i;
        n_cmp++;
        if (bad >= 0) begin
            n_bad++;
            if (s + bad < obs_q.size())
                $display("FAIL %s stream: write %0d got %h expected %h", name, bad, obs_q[s + bad], exp_q[bad]);
            else
                $display("FAIL %s stream: write %0d got none expected %h", name, bad, exp_q[bad]);
        end
        n_cmp++;
        if (done_cnt - d0 !== (cap ? 1 : 0)) begin
            n_bad++; $display("FAIL %s done: got %0d expected %0d", name, done_cnt - d0, cap ? 1 : 0);
        end
        n_cmp++;
        if (bus.overflow !== ovf_exp) begin
            n_bad++; $display("FAIL %s overflow: got %b expected %b", name, bus.overflow, ovf_exp);
        end
    endtask

    task automatic test_odd_line();
        int lens[$];
        lens = '{321, 320};
        run_and_check("odd_line", lens, 1'b0, -1, 1'b1);
    endtask

    task automatic test_full_frame();
        int lens[$];
        repeat (120) lens.push_back(320);
        run_and_check("full_frame", lens, 1'b1, -1, 1'b1);
    endtask

    task automatic test_overflow_cam_en_drop();
        int lens[$];
        repeat (121) lens.push_back(320);
        run_and_check("overflow_drop", lens, 1'b0, 60, 1'b1);
        n_cmp++;
        if (bus.mem_px_addr !== 15'd19199) begin
            n_bad++; $display("FAIL overflow_last_addr: got %0d expected 19199", bus.mem_px_addr);
        end
    endtask

    task automatic test_disabled_frame();
        int lens[$];
        lens = '{320, 320, 320};
        run_and_check("disabled", lens, 1'b0, -1, 1'b0);
    endtask

    task automatic test_back_to_back();
        int lens[$];
        bus.cam_en = 1'b1;
        lens = '{320, 320};
        run_and_check("reenable", lens, 1'b0, -1, 1'b1);
        lens = '{160};
        run_and_check("back_to_back", lens, 1'b1, -1, 1'b1);
    endtask

    initial begin
        test_reset();
        test_single_pixel();
        test_odd_line();
        test_full_frame();
        test_overflow_cam_en_drop();
        test_disabled_frame();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
